// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one Booth multiplier between NUM_REQ clients.
// Operands are accepted in IDLE, one multiply is kept in flight, and the result returns with its owner's ID.
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  input  logic                         mul_done,
  input  logic [2*WIDTH-1:0]           mul_p,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [2*WIDTH-1:0]           resp_p,
  output logic                         resp_err,
  output logic                         err_timeout,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nx;
  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    id_r;
  logic [TMR_W-1:0]   timer_r;

  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [WIDTH-1:0]   grant_a_s;
  logic [WIDTH-1:0]   grant_b_s;
  logic               accept_s;
  logic               done_s;
  logic               abort_s;
  logic               tick_s;
  logic               release_s;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [ID_W:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_r} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!grant_found_s && req_valid[cand[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    grant_a_s = req_a[grant_idx_s*WIDTH +: WIDTH];
    grant_b_s = req_b[grant_idx_s*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode, the combinational grant and per-cycle datapath strobes.
  always_comb begin
    state_nx  = state_r;
    req_ready = '0;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    abort_s   = 1'b0;
    tick_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready[grant_idx_s] = 1'b1;
          accept_s               = 1'b1;
          state_nx               = ST_ISSUE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (mul_done) begin
          done_s   = 1'b1;
          state_nx = ST_RESP;
        end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
          abort_s  = 1'b1;
          state_nx = ST_RESP;
        end else begin
          tick_s   = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          release_s = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Operand/ID latches, timeout timer, response registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      id_r         <= '0;
      timer_r      <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_p       <= '0;
      resp_err     <= 1'b0;
      err_timeout  <= 1'b0;
      busy         <= 1'b0;
      last_grant_r <= ID_W'(NUM_REQ - 1);
    end else begin
      mul_start  <= accept_s;
      resp_valid <= (state_nx == ST_RESP);
      busy       <= (state_nx != ST_IDLE);
      if (accept_s) begin
        mul_a <= grant_a_s;
        mul_b <= grant_b_s;
        id_r  <= grant_idx_s;
      end
      if (state_r == ST_ISSUE) begin
        timer_r <= '0;
      end else if (tick_s) begin
        timer_r <= timer_r + TMR_W'(1);
      end
      if (done_s) begin
        resp_p   <= mul_p;
        resp_err <= 1'b0;
        resp_id  <= id_r;
      end else if (abort_s) begin
        resp_p      <= '0;
        resp_err    <= 1'b1;
        resp_id     <= id_r;
        err_timeout <= 1'b1;
      end
      if (release_s) begin
        last_grant_r <= resp_id;
      end
    end
  end

endmodule
